uart_tx_fifo: RTL

// - UART transmitter, 8N1 (1 start, 8 data LSB-first, 1 stop, no parity), with a small input FIFO.
// - Sits between on-chip byte producers and the serial TX pin.
// - Peer of the team's UART receiver: same CLOCKS_PER_BIT convention, so a loopback pair interoperates.
// - The FIFO lets producers queue bytes so frames go out back-to-back with no idle gap.

---
 rtl/uart_tx_fifo.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
`timescale 1ns/1ps
// uart_tx_fifo
// 8N1 UART transmitter with a small input FIFO. Producers queue bytes through
// a valid/ready style write port. The FSM sends each byte as one start bit,
// eight data bits LSB-first, and one stop bit, each CLOCKS_PER_BIT cycles long.
// Queued bytes go out back-to-back with no idle cycle between frames.
//
// Ports
//   i_Clk        : system clock, rising edge
//   i_Rst_n      : asynchronous active-low reset
//   i_TX_DV      : write strobe; byte accepted when i_TX_DV && o_TX_Ready
//   i_TX_Byte    : byte to queue, sampled with i_TX_DV
//   o_TX_Ready   : FIFO not full
//   o_TX_Serial  : registered serial line, idles high
//   o_TX_Active  : high while a frame (start..stop) is on the line
//   o_TX_Done    : one-cycle pulse after each stop bit completes
//   o_FIFO_Count : bytes queued, not counting the frame in flight
module uart_tx_fifo #(
  parameter int CLOCKS_PER_BIT = 217,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                              i_Clk,
  input  logic                              i_Rst_n,
  input  logic                              i_TX_DV,
  input  logic [7:0]                        i_TX_Byte,
  output logic                              o_TX_Ready,
  output logic                              o_TX_Serial,
  output logic                              o_TX_Active,
  output logic                              o_TX_Done,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   o_FIFO_Count
);

  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int BAUD_W = $clog2(CLOCKS_PER_BIT);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // ---------------------------------------------------------------- FIFO
  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;

  // Ready looks only at the registered count, so a pop on the same edge
  // never lets a write into a full FIFO.
  assign o_TX_Ready   = (count != CNT_W'(FIFO_DEPTH));
  assign push         = i_TX_DV && o_TX_Ready;
  assign o_FIFO_Count = count;

  // NOTE: the storage array has no reset; pointers and count alone decide
  // which entries are valid, so clearing the data would buy nothing.
  always_ff @(posedge i_Clk) begin
    if (push) fifo_mem[wr_ptr] <= i_TX_Byte;
  end

  // Pointers are PTR_W bits wide and FIFO_DEPTH is a power of two, so
  // they wrap modulo the depth without extra logic.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------- FSM
  state_t            state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        idx_q, idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              serial_q, serial_d;
  logic              done_q, done_d;
  logic              baud_last;

  assign baud_last = (baud_q == BAUD_W'(CLOCKS_PER_BIT - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; the combinational block below uses blocking.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      serial_q <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      serial_q <= serial_d;
      done_q   <= done_d;
    end
  end

  // The line value is computed one cycle ahead and registered, so each bit
  // change lands on the same edge as the state change that causes it.
  always_comb begin
    // NOTE: every output of this block gets a default first; without it a
    // path that skips an assignment would infer a latch.
    state_d  = state_q;
    baud_d   = baud_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    serial_d = serial_q;
    done_d   = 1'b0;
    pop      = 1'b0;

    case (state_q)
      IDLE: begin
        serial_d = 1'b1;
        baud_d   = '0;
        if (count != '0) begin
          pop      = 1'b1;
          shift_d  = fifo_mem[rd_ptr];
          state_d  = START;
          serial_d = 1'b0;
        end
      end

      START: begin
        if (baud_last) begin
          baud_d   = '0;
          idx_d    = '0;
          state_d  = DATA;
          serial_d = shift_q[0];
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      DATA: begin
        if (baud_last) begin
          baud_d = '0;
          if (idx_q == 3'd7) begin
            state_d  = STOP;
            serial_d = 1'b1;
          end else begin
            idx_d    = idx_q + 3'd1;
            serial_d = shift_q[idx_q + 3'd1];
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      STOP: begin
        serial_d = 1'b1;
        if (baud_last) begin
          baud_d = '0;
          done_d = 1'b1;
          // Chain straight into the next start bit when bytes are waiting.
          if (count != '0) begin
            pop      = 1'b1;
            shift_d  = fifo_mem[rd_ptr];
            state_d  = START;
            serial_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      default: begin
        state_d  = IDLE;
        serial_d = 1'b1;
      end
    endcase
  end

  assign o_TX_Serial = serial_q;
  assign o_TX_Active = (state_q != IDLE);
  assign o_TX_Done   = done_q;

endmodule
